// File: rtl/disco_core_mc_if.sv
// Memory port of the DISCO core: one outstanding req/ack transaction at a time.
// The core is the master; the memory model or SoC fabric is the slave.
interface disco_core_mc_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/disco_core_mc.sv
// Multi-cycle DISCO core: FETCH -> [FETCH_IMM] -> EXEC -> [MEM] over a req/ack port,
// with sticky halt and illegal-instruction trap status.
module disco_core_mc #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                NUM_REGS = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  disco_core_mc_if.master      mem,
  output logic                 halted,
  output logic                 trap,
  output logic [ADDR_W-1:0]    dbg_pc
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] OP_LOG    = 3'd0;
  localparam logic [2:0] OP_SHIFT  = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_LS     = 3'd3;
  localparam logic [2:0] OP_TEST   = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_IMM,
    S_EXEC,
    S_MEM,
    S_HALT,
    S_TRAP
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rf [NUM_REGS];

  // Instruction fields
  logic [2:0] op1;
  logic [3:0] op2;
  logic       i_bit;
  logic [3:0] ra, rb;

  assign op1   = ir[15:13];
  assign op2   = ir[12:9];
  assign i_bit = ir[8];
  assign ra    = ir[7:4];
  assign rb    = ir[3:0];

  logic [DATA_W-1:0] ra_val, rb_val, b_val, ea_sum;
  logic [SH_W-1:0]   shamt;
  logic              ra_bad, rb_bad;

  assign ra_val = rf[ra];
  assign rb_val = rf[rb];
  assign b_val  = i_bit ? imm : rb_val;
  assign shamt  = b_val[SH_W-1:0];
  assign ra_bad = int'(ra) >= NUM_REGS;
  assign rb_bad = int'(rb) >= NUM_REGS;
  assign ea_sum = rb_val + (i_bit ? imm : '0);

  logic [ADDR_W-1:0] mem_ea, br_target, pc_seq;

  assign mem_ea    = ADDR_W'(ea_sum) & ~ADDR_W'(1);
  assign br_target = ADDR_W'(imm) & ~ADDR_W'(1);
  assign pc_seq    = pc + (i_bit ? ADDR_W'(4) : ADDR_W'(2));

  // Decode / execute results for the instruction held in IR
  logic              illegal, is_hlt, is_ls, is_store, wr_en, take;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] pc_exec;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    illegal  = 1'b0;
    is_hlt   = 1'b0;
    is_ls    = 1'b0;
    is_store = 1'b0;
    wr_en    = 1'b0;
    take     = 1'b0;
    wr_data  = '0;

    case (op1)
      OP_LOG: begin
        wr_en = 1'b1;
        case (op2)
          4'd0:    wr_data = ra_val & b_val;
          4'd1:    wr_data = ra_val | b_val;
          4'd2:    wr_data = ra_val ^ b_val;
          4'd3:    wr_data = ra_val + b_val;
          4'd4:    wr_data = ra_val - b_val;
          default: illegal = 1'b1;
        endcase
        if (ra_bad || (!i_bit && rb_bad)) illegal = 1'b1;
      end

      OP_SHIFT: begin
        wr_en = 1'b1;
        case (op2)
          4'd0:    wr_data = ra_val << shamt;
          4'd1:    wr_data = ra_val >> shamt;
          4'd2:    wr_data = $unsigned($signed(ra_val) >>> shamt);
          default: illegal = 1'b1;
        endcase
        if (ra_bad || (!i_bit && rb_bad)) illegal = 1'b1;
      end

      OP_BRANCH: begin
        case (op2)
          4'd0:    take = $signed(ra_val) <  $signed(rb_val);
          4'd1:    take = $signed(ra_val) >= $signed(rb_val);
          4'd2:    take = ra_val <  rb_val;
          4'd3:    take = ra_val >= rb_val;
          4'd4:    take = ra_val == rb_val;
          4'd5:    take = ra_val != rb_val;
          default: illegal = 1'b1;
        endcase
        // The branch target lives in the immediate word, so I=0 is malformed
        if (!i_bit || ra_bad || rb_bad) illegal = 1'b1;
      end

      OP_LS: begin
        is_ls = 1'b1;
        case (op2)
          4'd0:    is_store = 1'b0;
          4'd1:    is_store = 1'b1;
          default: illegal  = 1'b1;
        endcase
        if (ra_bad || rb_bad) illegal = 1'b1;
      end

      OP_TEST: begin
        case (op2)
          4'd0:    is_hlt  = 1'b0;
          4'hF:    is_hlt  = 1'b1;
          default: illegal = 1'b1;
        endcase
      end

      default: illegal = 1'b1;
    endcase

    pc_exec = take ? br_target : pc_seq;
  end

  // Next-state and memory-port drive
  logic              req, we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    state_next = state;
    req        = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;

    case (state)
      S_FETCH: begin
        req  = 1'b1;
        addr = pc;
        if (mem.mem_ack) state_next = mem.mem_rdata[8] ? S_FETCH_IMM : S_EXEC;
      end

      S_FETCH_IMM: begin
        req  = 1'b1;
        addr = pc + ADDR_W'(2);
        if (mem.mem_ack) state_next = S_EXEC;
      end

      S_EXEC: begin
        if (illegal)     state_next = S_TRAP;
        else if (is_hlt) state_next = S_HALT;
        else if (is_ls)  state_next = S_MEM;
        else             state_next = S_FETCH;
      end

      S_MEM: begin
        req   = 1'b1;
        we    = is_store;
        addr  = mem_ea;
        wdata = is_store ? ra_val : '0;
        if (mem.mem_ack) state_next = S_FETCH;
      end

      S_HALT, S_TRAP: state_next = state;

      default: state_next = S_TRAP;
    endcase
  end

  // The state register resets to FETCH, so the bus is masked by reset itself
  // to keep mem_req low for the whole reset pulse and drop it the moment reset hits.
  assign mem.mem_req   = req & reset;
  assign mem.mem_we    = we & reset;
  assign mem.mem_addr  = reset ? addr  : '0;
  assign mem.mem_wdata = reset ? wdata : '0;

  assign halted = (state == S_HALT);
  assign trap   = (state == S_TRAP);
  assign dbg_pc = pc;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      imm   <= '0;
      // NOTE: the register file is architecturally zero after reset, so it is
      // reset here; a plain data RAM would normally be left unreset.
      for (int k = 0; k < NUM_REGS; k++) rf[k] <= '0;
    end else begin
      state <= state_next;

      if (state == S_FETCH && mem.mem_ack)     ir  <= mem.mem_rdata[15:0];
      if (state == S_FETCH_IMM && mem.mem_ack) imm <= mem.mem_rdata;

      if (state == S_EXEC && !illegal && !is_hlt && !is_ls) begin
        pc <= pc_exec;
        if (wr_en) rf[ra] <= wr_data;
      end

      // Load/store retires only once the data phase completes
      if (state == S_MEM && mem.mem_ack) begin
        pc <= pc_exec;
        if (!is_store) rf[ra] <= mem.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_disco_core_mc.sv
// Directed bench for disco_core_mc: req/ack memory model with programmable wait
// states, transaction log, and hand-computed expected results.
module tb_disco_core_mc;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              halted, trap;
  logic [ADDR_W-1:0] dbg_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  disco_core_mc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  disco_core_mc #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(16),
    .RESET_PC(16'h0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .mem   (bus),
    .halted(halted),
    .trap  (trap),
    .dbg_pc(dbg_pc)
  );

  // Memory model: program image plus a write overlay cleared on reset
  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } txn_t;

  txn_t        log_q[$];
  logic [15:0] rom [0:1023];
  logic [15:0] ram [0:1023];
  logic        written [0:1023];
  logic [9:0]  idx;
  int          wait_cycles = 0;
  int          wait_cnt;
  int          hold_err;
  logic        stale_ack = 1'b0;
  logic        held_v, held_we;
  logic [15:0] held_addr, held_wdata;
  int          wp;

  assign idx           = bus.mem_addr[10:1];
  assign bus.mem_rdata = written[idx] ? ram[idx] : rom[idx];
  assign bus.mem_ack   = (bus.mem_req && wait_cnt >= wait_cycles) || stale_ack;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 0;
      held_v   <= 1'b0;
      hold_err <= 0;
      log_q.delete();
      for (int k = 0; k < 1024; k++) written[k] <= 1'b0;
    end else if (bus.mem_req) begin
      if (held_v && (bus.mem_addr !== held_addr || bus.mem_we !== held_we ||
                     bus.mem_wdata !== held_wdata))
        hold_err <= hold_err + 1;
      if (bus.mem_ack) begin
        wait_cnt <= 0;
        held_v   <= 1'b0;
        log_q.push_back(txn_t'{bus.mem_addr, bus.mem_we, bus.mem_wdata});
        if (bus.mem_we) begin
          ram[idx]     <= bus.mem_wdata;
          written[idx] <= 1'b1;
        end
      end else begin
        wait_cnt   <= wait_cnt + 1;
        held_v     <= 1'b1;
        held_addr  <= bus.mem_addr;
        held_we    <= bus.mem_we;
        held_wdata <= bus.mem_wdata;
      end
    end else if (held_v) begin
      hold_err <= hold_err + 1;
      held_v   <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [2:0] op1, input logic [3:0] op2,
                                      input logic i, input logic [3:0] ra,
                                      input logic [3:0] rb);
    return {op1, op2, i, ra, rb};
  endfunction

  task automatic clear_rom();
    for (int k = 0; k < 1024; k++) rom[k] = 16'hA000;  // op1=5: traps if reached
    wp = 0;
  endtask

  task automatic org(input int byte_addr);
    wp = byte_addr >> 1;
  endtask

  task automatic emit(input logic [15:0] w);
    rom[wp] = w;
    wp++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_to_end(input int budget, output int cycles);
    cycles = 0;
    while (!halted && !trap && cycles < budget) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    check("run_finished", 32'(halted | trap), 32'd1);
  endtask

  initial begin
    int          cyc;
    int          n_wr;
    logic        hit;
    int          exp_f [17];
    logic [15:0] bad [3];

    #1 reset = 1'b0;
    #2;
    check("rst_req",    32'(bus.mem_req),   32'd0);
    check("rst_we",     32'(bus.mem_we),    32'd0);
    check("rst_addr",   32'(bus.mem_addr),  32'd0);
    check("rst_wdata",  32'(bus.mem_wdata), 32'd0);
    check("rst_halted", 32'(halted),        32'd0);
    check("rst_trap",   32'(trap),          32'd0);
    check("rst_pc",     32'(dbg_pc),        32'd0);

    // Zero-wait timing: ADD I r1,5 ; ADD r1,r1 ; HLT
    clear_rom();
    emit(ins(3'd0, 4'd3, 1'b1, 4'd1, 4'd0)); emit(16'h0005);
    emit(ins(3'd0, 4'd3, 1'b0, 4'd1, 4'd1));
    emit(ins(3'd7, 4'hF, 1'b0, 4'd0, 4'd0));
    wait_cycles = 0;
    do_reset();
    check("t1_pc_0",    32'(dbg_pc),       32'h0);
    check("t1_req_0",   32'(bus.mem_req),  32'd1);
    tick(3); check("t1_pc_4",   32'(dbg_pc), 32'h4);
    tick(2); check("t1_pc_6",   32'(dbg_pc), 32'h6);
    tick(1); check("t1_halt_c7", 32'(halted), 32'd0);
    tick(1); check("t1_halt_c8", 32'(halted), 32'd1);
    check("t1_r1",      32'(dut.rf[1]),    32'h000A);
    check("t1_req_off", 32'(bus.mem_req),  32'd0);

    // SUB wrap, shifts and logic ops, results stored to 0x200..0x206
    clear_rom();
    emit(ins(3'd0, 4'd4, 1'b1, 4'd2, 4'd0)); emit(16'h0001);
    emit(ins(3'd3, 4'd1, 1'b1, 4'd2, 4'd0)); emit(16'h0200);
    emit(ins(3'd1, 4'd2, 1'b1, 4'd2, 4'd0)); emit(16'h0004);
    emit(ins(3'd3, 4'd1, 1'b1, 4'd2, 4'd0)); emit(16'h0202);
    emit(ins(3'd1, 4'd1, 1'b1, 4'd2, 4'd0)); emit(16'h0004);
    emit(ins(3'd3, 4'd1, 1'b1, 4'd2, 4'd0)); emit(16'h0204);
    emit(ins(3'd0, 4'd3, 1'b1, 4'd8, 4'd0)); emit(16'h00F0);
    emit(ins(3'd0, 4'd1, 1'b1, 4'd8, 4'd0)); emit(16'h0F00);
    emit(ins(3'd0, 4'd2, 1'b1, 4'd8, 4'd0)); emit(16'h00FF);
    emit(ins(3'd0, 4'd0, 1'b1, 4'd8, 4'd0)); emit(16'h0FF0);
    emit(ins(3'd1, 4'd0, 1'b1, 4'd8, 4'd0)); emit(16'h0004);
    emit(ins(3'd3, 4'd1, 1'b1, 4'd8, 4'd0)); emit(16'h0206);
    emit(ins(3'd7, 4'hF, 1'b0, 4'd0, 4'd0));
    do_reset();
    run_to_end(200, cyc);
    check("t2_trap",     32'(trap),       32'd0);
    check("t2_sub_wrap", 32'(ram[9'h100]), 32'hFFFF);
    check("t2_asr",      32'(ram[9'h101]), 32'hFFFF);
    check("t2_lsr",      32'(ram[9'h102]), 32'h0FFF);
    check("t2_logic",    32'(ram[9'h103]), 32'hF000);

    // Branches; every unlisted word traps, so a wrong path is visible
    clear_rom();
    emit(ins(3'd0, 4'd3, 1'b1, 4'd3, 4'd0)); emit(16'hFFFE);
    emit(ins(3'd0, 4'd3, 1'b1, 4'd4, 4'd0)); emit(16'h0001);
    emit(ins(3'd2, 4'd0, 1'b1, 4'd3, 4'd4)); emit(16'h0040);  // BLT taken
    org(16'h40);
    emit(ins(3'd2, 4'd2, 1'b1, 4'd3, 4'd4)); emit(16'h0080);  // BBL not taken
    emit(ins(3'd2, 4'd5, 1'b1, 4'd4, 4'd4)); emit(16'h0080);  // BNE not taken
    emit(ins(3'd2, 4'd4, 1'b1, 4'd4, 4'd4)); emit(16'h0060);  // BEQ taken
    org(16'h60);
    emit(ins(3'd2, 4'd1, 1'b1, 4'd3, 4'd4)); emit(16'h0080);  // BGE not taken
    emit(ins(3'd2, 4'd3, 1'b1, 4'd3, 4'd4)); emit(16'h0071);  // BAE taken, bit0 dropped
    org(16'h70);
    emit(ins(3'd7, 4'hF, 1'b0, 4'd0, 4'd0));
    do_reset();
    run_to_end(200, cyc);
    check("t3_halted", 32'(halted), 32'd1);
    check("t3_trap",   32'(trap),   32'd0);
    check("t3_pc",     32'(dbg_pc), 32'h70);
    exp_f = '{32'h00, 32'h02, 32'h04, 32'h06, 32'h08, 32'h0A, 32'h40, 32'h42, 32'h44,
              32'h46, 32'h48, 32'h4A, 32'h60, 32'h62, 32'h64, 32'h66, 32'h70};
    check("t3_nfetch", 32'(log_q.size()), 32'd17);
    for (int k = 0; k < 17 && k < log_q.size(); k++)
      check($sformatf("t3_fetch%0d", k), 32'(log_q[k].addr), 32'(exp_f[k]));

    // Three wait states on every access: ST / LD / ST with immediate
    clear_rom();
    emit(ins(3'd0, 4'd3, 1'b1, 4'd5, 4'd0)); emit(16'h1234);
    emit(ins(3'd0, 4'd3, 1'b1, 4'd6, 4'd0)); emit(16'h0100);
    emit(ins(3'd3, 4'd1, 1'b0, 4'd5, 4'd6));
    emit(ins(3'd3, 4'd0, 1'b0, 4'd7, 4'd6));
    emit(ins(3'd3, 4'd1, 1'b1, 4'd7, 4'd6)); emit(16'h0002);
    emit(ins(3'd7, 4'hF, 1'b0, 4'd0, 4'd0));
    wait_cycles = 3;
    do_reset();
    run_to_end(300, cyc);
    check("t4_cycles",  32'(cyc),        32'd54);
    check("t4_r7",      32'(dut.rf[7]),  32'h1234);
    check("t4_hold",    32'(hold_err),   32'd0);
    n_wr = 0;
    foreach (log_q[k]) begin
      if (log_q[k].we) begin
        check($sformatf("t4_st%0d_addr", n_wr), 32'(log_q[k].addr),
              (n_wr == 0) ? 32'h0100 : 32'h0102);
        check($sformatf("t4_st%0d_data", n_wr), 32'(log_q[k].wdata), 32'h1234);
        n_wr++;
      end
    end
    check("t4_nstores", 32'(n_wr), 32'd2);

    // Illegal encodings: op1=5, BRANCH with I=0, LOG_ARITH op2=7
    bad[0] = ins(3'd5, 4'd0, 1'b0, 4'd9, 4'd9);
    bad[1] = ins(3'd2, 4'd4, 1'b0, 4'd9, 4'd9);
    bad[2] = ins(3'd0, 4'd7, 1'b0, 4'd9, 4'd9);
    wait_cycles = 0;
    for (int b = 0; b < 3; b++) begin
      clear_rom();
      emit(ins(3'd0, 4'd3, 1'b1, 4'd9, 4'd0)); emit(16'h0055);
      emit(bad[b]);
      emit(ins(3'd7, 4'hF, 1'b0, 4'd0, 4'd0));
      do_reset();
      run_to_end(50, cyc);
      check($sformatf("t5_%0d_trap", b),   32'(trap),       32'd1);
      check($sformatf("t5_%0d_halted", b), 32'(halted),     32'd0);
      check($sformatf("t5_%0d_r9", b),     32'(dut.rf[9]),  32'h0055);
      check($sformatf("t5_%0d_pc", b),     32'(dbg_pc),     32'h4);
      tick(3);
      check($sformatf("t5_%0d_req", b),    32'(bus.mem_req), 32'd0);
      check($sformatf("t5_%0d_sticky", b), 32'(trap),        32'd1);
    end

    // Reset during FETCH_IMM with a stale ack held through reset
    clear_rom();
    emit(ins(3'd0, 4'd3, 1'b1, 4'd10, 4'd0)); emit(16'h0777);
    emit(ins(3'd7, 4'hF, 1'b0, 4'd0, 4'd0));
    wait_cycles = 3;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t6_trap_clr", 32'(trap), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      tick(1);
      if (bus.mem_req && bus.mem_addr == 16'h0002) hit = 1'b1;
    end
    check("t6_in_fetch_imm", 32'(hit), 32'd1);
    tick(1);
    reset     = 1'b0;
    stale_ack = 1'b1;
    #1;
    check("t6_req_drop",  32'(bus.mem_req),  32'd0);
    check("t6_addr_drop", 32'(bus.mem_addr), 32'd0);
    check("t6_pc_reset",  32'(dbg_pc),       32'd0);
    tick(2);
    check("t6_req_in_rst", 32'(bus.mem_req), 32'd0);
    @(negedge clock);
    reset     = 1'b1;
    stale_ack = 1'b0;
    #1;
    check("t6_refetch_req",  32'(bus.mem_req),  32'd1);
    check("t6_refetch_addr", 32'(bus.mem_addr), 32'd0);
    run_to_end(100, cyc);
    check("t6_halted", 32'(halted),      32'd1);
    check("t6_r10",    32'(dut.rf[10]),  32'h0777);
    check("t6_first",  (log_q.size() > 0) ? 32'(log_q[0].addr) : 32'hDEAD, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
